systolic_pe: RTL



---
 rtl/systolic_pkg.sv | 60 ++++++
 rtl/systolic_pe_if.sv | 36 +++
 rtl/systolic_acc_add.sv | 27 ++
 rtl/systolic_pe.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, types and arithmetic helpers for the systolic PE
package systolic_pkg;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_OS   = 1'b1;

  // Helpers work on a fixed wide vector; callers zero-pad in and slice out.
  localparam int MAX_W = 128;
  localparam int IDX_W = $clog2(MAX_W);

  typedef logic [MAX_W-1:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t sum;
  } add_res_t;

  typedef enum logic [1:0] {
    DRAIN_NONE = 2'd0,
    DRAIN_FWD  = 2'd1,
    DRAIN_RES  = 2'd2
  } drain_e;

  // Extend a prod_w-bit product to the full wide vector (sign or zero fill).
  function automatic wide_t ext_prod(input wide_t prod, input int prod_w, input bit is_signed);
    wide_t mask;
    mask = (wide_t'(1) << prod_w) - wide_t'(1);
    if (is_signed && prod[IDX_W'(prod_w - 1)]) return prod | ~mask;
    return prod & mask;
  endfunction

  // acc_w-bit add with overflow detection and optional clamp to the acc_w range.
  function automatic add_res_t sat_add(input wide_t x, input wide_t y, input int acc_w,
                                       input bit is_signed, input bit saturate);
    add_res_t res;
    wide_t mask, sum, max_v, min_v;
    logic [IDX_W-1:0] hi, top;
    logic ovf, neg;
    hi   = IDX_W'(acc_w - 1);
    top  = IDX_W'(acc_w);
    mask = (wide_t'(1) << acc_w) - wide_t'(1);
    sum  = (x & mask) + (y & mask);
    if (is_signed) begin
      ovf   = (x[hi] == y[hi]) && (sum[hi] != x[hi]);
      neg   = x[hi];
      max_v = (wide_t'(1) << (acc_w - 1)) - wide_t'(1);
      min_v = wide_t'(1) << (acc_w - 1);
    end else begin
      ovf   = sum[top];
      neg   = 1'b0;
      max_v = mask;
      min_v = '0;
    end
    if (ovf && saturate) sum = neg ? min_v : max_v;
    res.ovf = ovf;
    res.sum = sum & mask;
    return res;
  endfunction

endpackage

// File: rtl/systolic_pe_if.sv
// rtl/systolic_pe_if.sv - operand, partial-sum and flag bundle of one processing element
interface systolic_pe_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic              mode_os;
  logic              clr;
  logic [DATA_W-1:0] a_in;
  logic              a_valid_in;
  logic              a_last_in;
  logic [DATA_W-1:0] b_in;
  logic              b_valid_in;
  logic [ACC_W-1:0]  c_in;
  logic              c_valid_in;
  logic [DATA_W-1:0] a_out;
  logic              a_valid_out;
  logic              a_last_out;
  logic [DATA_W-1:0] b_out;
  logic              b_valid_out;
  logic [ACC_W-1:0]  c_out;
  logic              c_valid_out;
  logic              ovf;
  logic              drop;

  // Upstream/neighbour side
  modport master (
    output mode_os, clr, a_in, a_valid_in, a_last_in, b_in, b_valid_in, c_in, c_valid_in,
    input  a_out, a_valid_out, a_last_out, b_out, b_valid_out, c_out, c_valid_out, ovf, drop
  );

  // Processing element side
  modport slave (
    input  mode_os, clr, a_in, a_valid_in, a_last_in, b_in, b_valid_in, c_in, c_valid_in,
    output a_out, a_valid_out, a_last_out, b_out, b_valid_out, c_out, c_valid_out, ovf, drop
  );
endinterface

// File: rtl/systolic_acc_add.sv
// rtl/systolic_acc_add.sv - combinational ACC_W adder with clamp and overflow flag
module systolic_acc_add
  import systolic_pkg::*;
#(
  parameter int ACC_W    = 40,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b0
) (
  input  logic [ACC_W-1:0] x,
  input  logic [ACC_W-1:0] y,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  add_res_t res;
  logic     unused_hi;

  // Widen, add with clamp/overflow, and narrow back to ACC_W
  always_comb begin
    res = sat_add(wide_t'(x), wide_t'(y), ACC_W, SIGNED, SATURATE);
    sum = res.sum[ACC_W-1:0];
    ovf = res.ovf;
  end

  assign unused_hi = ^res.sum[MAX_W-1:ACC_W];

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - systolic multiply-accumulate processing element (pass / output-stationary)
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  systolic_pe_if.slave bus
);

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
    $error("systolic_pe: ACC_W must be at least 2*DATA_W");
  end
  if (ACC_W >= MAX_W) begin : g_bad_max_w
    $error("systolic_pe: ACC_W must be below the package helper width");
  end

  logic                fire;
  logic [2*DATA_W-1:0] a_ext, b_ext, prod_raw;
  wide_t               prod_wide;
  logic [ACC_W-1:0]    prod_ext;
  logic                unused_prod_hi;

  logic [DATA_W-1:0]   a_q, b_q;
  logic                a_v_q, a_last_q, b_v_q;
  logic [ACC_W-1:0]    prod_q, c_d, acc, res_q, c_q;
  logic                prod_v, prod_last, pending, c_v_q, ovf_q, drop_q;

  logic [ACC_W-1:0]    pass_sum, acc_sum;
  logic                pass_ovf, acc_ovf;
  drain_e              drain_sel;
  logic                res_load, res_emit;

  assign fire = bus.a_valid_in & bus.b_valid_in;

  // Operand extension and the full-width product feeding the product register
  always_comb begin
    a_ext     = SIGNED ? {{DATA_W{bus.a_in[DATA_W-1]}}, bus.a_in} : {{DATA_W{1'b0}}, bus.a_in};
    b_ext     = SIGNED ? {{DATA_W{bus.b_in[DATA_W-1]}}, bus.b_in} : {{DATA_W{1'b0}}, bus.b_in};
    prod_raw  = a_ext * b_ext;
    prod_wide = ext_prod(wide_t'(prod_raw), 2 * DATA_W, SIGNED);
    prod_ext  = prod_wide[ACC_W-1:0];
  end

  assign unused_prod_hi = ^prod_wide[MAX_W-1:ACC_W];

  systolic_acc_add #(.ACC_W(ACC_W), .SIGNED(SIGNED), .SATURATE(SATURATE)) u_pass_add (
    .x(c_d), .y(prod_q), .sum(pass_sum), .ovf(pass_ovf)
  );

  systolic_acc_add #(.ACC_W(ACC_W), .SIGNED(SIGNED), .SATURATE(SATURATE)) u_acc_add (
    .x(acc), .y(prod_q), .sum(acc_sum), .ovf(acc_ovf)
  );

  // Drain arbitration: upstream results win over the local pending result
  always_comb begin
    drain_sel = DRAIN_NONE;
    if (bus.c_valid_in)  drain_sel = DRAIN_FWD;
    else if (pending)    drain_sel = DRAIN_RES;
    res_load = (bus.mode_os == MODE_OS) && prod_v && prod_last;
    res_emit = (drain_sel == DRAIN_RES);
  end

  // Forward west/north operands one cycle on; clr leaves this path alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      a_v_q    <= 1'b0;
      a_last_q <= 1'b0;
      b_q      <= '0;
      b_v_q    <= 1'b0;
    end else begin
      a_q      <= bus.a_in;
      a_v_q    <= bus.a_valid_in;
      a_last_q <= bus.a_last_in;
      b_q      <= bus.b_in;
      b_v_q    <= bus.b_valid_in;
    end
  end

  // Product stage, pass-mode sum, local accumulation, drain and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q    <= '0;
      prod_v    <= 1'b0;
      prod_last <= 1'b0;
      c_d       <= '0;
      acc       <= '0;
      res_q     <= '0;
      pending   <= 1'b0;
      c_q       <= '0;
      c_v_q     <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else if (bus.clr) begin
      acc     <= '0;
      prod_v  <= 1'b0;
      c_d     <= '0;
      pending <= 1'b0;
      c_v_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      prod_v <= fire;
      if (fire) begin
        prod_q    <= prod_ext;
        prod_last <= bus.a_last_in;
      end
      c_d <= bus.c_valid_in ? bus.c_in : '0;
      if (bus.mode_os == MODE_PASS) begin
        c_v_q <= prod_v;
        if (prod_v) begin
          c_q <= pass_sum;
          if (pass_ovf) ovf_q <= 1'b1;
        end
      end else begin
        if (prod_v) begin
          if (acc_ovf) ovf_q <= 1'b1;
          if (prod_last) begin
            res_q <= acc_sum;
            acc   <= '0;
          end else begin
            acc <= acc_sum;
          end
        end
        case (drain_sel)
          DRAIN_FWD: begin c_q <= bus.c_in; c_v_q <= 1'b1; end
          DRAIN_RES: begin c_q <= res_q;    c_v_q <= 1'b1; end
          default:   c_v_q <= 1'b0;
        endcase
        pending <= res_load | (pending & ~res_emit);
        if (res_load && pending && !res_emit) drop_q <= 1'b1;
      end
    end
  end

  assign bus.a_out       = a_q;
  assign bus.a_valid_out = a_v_q;
  assign bus.a_last_out  = a_last_q;
  assign bus.b_out       = b_q;
  assign bus.b_valid_out = b_v_q;
  assign bus.c_out       = c_q;
  assign bus.c_valid_out = c_v_q;
  assign bus.ovf         = ovf_q;
  assign bus.drop        = drop_q;

endmodule
